button_conditioner: RTL

Front-end input stage for the combination-lock FSM. Takes the raw, asynchronous zero/one push-buttons and the security switch, synchronises and debounces them, and produces the clean signals the lock FSM consumes: single-cycle press pulses on ZBUT/OBUT and a debounced SECI level. It also flags ambiguous two-button presses so they never reach the FSM as a digit.

---
 rtl/button_conditioner.sv | 99 +++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Front-end conditioner for the combination-lock FSM: synchronises and debounces the zero/one
// buttons and the security switch, emits one-cycle press pulses, and flags two-button
// collisions so an ambiguous press never reaches the lock as a digit.
module button_conditioner #(
  parameter int unsigned DBNC_CYCLES = 4,
  parameter int unsigned CNTW        = $clog2(DBNC_CYCLES + 1)
) (
  input  logic clk,
  input  logic rstn,
  input  logic zraw,
  input  logic oraw,
  input  logic secr,
  input  logic enbl,
  output logic zbut,
  output logic obut,
  output logic seci,
  output logic coll
);

  // Channel order in the packed vectors: bit 0 = zero, bit 1 = one, bit 2 = security.
  localparam int NumCh = 3;
  localparam logic [CNTW-1:0] CntMax = CNTW'(DBNC_CYCLES - 1);

  logic [NumCh-1:0] raw;
  logic [NumCh-1:0] s1_q, s2_q;
  logic [NumCh-1:0] st_q, st_d;
  logic [CNTW-1:0]  cnt_q [NumCh];
  logic [CNTW-1:0]  cnt_d [NumCh];
  // Previous stable value, only needed on the two push-buttons for rise detection.
  logic [1:0]       prev_q;
  logic             zr, orr;
  logic             zbut_d, obut_d, coll_d;
  logic             zbut_q, obut_q, coll_q;

  assign raw = {secr, oraw, zraw};

  // Debounce: the stable bit flips only after DBNC_CYCLES consecutive synchronised mismatches;
  // any agreement clears the count, so glitches restart the run.
  always_comb begin
    for (int ch = 0; ch < NumCh; ch++) begin
      st_d[ch]  = st_q[ch];
      cnt_d[ch] = '0;
      if (s2_q[ch] != st_q[ch]) begin
        if (cnt_q[ch] == CntMax) begin
          st_d[ch] = ~st_q[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + CNTW'(1);
        end
      end
    end
  end

  assign zr  = st_q[0] & ~prev_q[0];
  assign orr = st_q[1] & ~prev_q[1];

  // Press arbitration: a rise while the other button is rising or already held is a collision.
  always_comb begin
    zbut_d = 1'b0;
    obut_d = 1'b0;
    coll_d = 1'b0;
    if (enbl) begin
      if ((zr && orr) || (zr && st_q[1]) || (orr && st_q[0])) begin
        coll_d = 1'b1;
      end else begin
        zbut_d = zr;
        obut_d = orr;
      end
    end
  end

  // State update with synchronous active-low reset; in-progress debounce counts are discarded.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q   <= '0;
      s2_q   <= '0;
      st_q   <= '0;
      cnt_q  <= '{default: '0};
      prev_q <= '0;
      zbut_q <= 1'b0;
      obut_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      prev_q <= st_q[1:0];
      zbut_q <= zbut_d;
      obut_q <= obut_d;
      coll_q <= coll_d;
    end
  end

  assign zbut = zbut_q;
  assign obut = obut_q;
  assign coll = coll_q;
  assign seci = st_q[2];

endmodule
